// File: rtl/interleave_block_scheduler.sv
// Round-robin block scheduler: one requester owns the vector interleaver for a full
// IIR*N-sample block. Define INTERLEAVE_SCHED_PAD_TIMEOUT_EN to zero-pad stalled blocks.
module interleave_block_scheduler #(
  parameter int BITS    = 8,
  parameter int IIR     = 3,
  parameter int N       = 10,
  parameter int V       = 2,
  parameter int R       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [R-1:0]         req_valid,
  input  logic [BITS-1:0]      req_data [R][V],
  output logic [R-1:0]         req_ready,
  output logic                 ilv_in_valid,
  output logic [BITS-1:0]      ilv_data [V],
  output logic [$clog2(R)-1:0] grant_id,
  output logic                 busy,
  output logic                 block_done,
  output logic                 pad_active
);
  localparam int L  = IIR * N;
  localparam int GW = $clog2(R);
  localparam int CW = (L > 1) ? $clog2(L) : 1;

`ifdef INTERLEAVE_SCHED_PAD_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, PASS, PAD} state_t;
`else
  typedef enum logic [1:0] {IDLE, PASS} state_t;
`endif

  if (R < 2 || TIMEOUT < 1) begin : g_bad_params
    $error("interleave_block_scheduler: needs R >= 2 and TIMEOUT >= 1");
  end

  state_t          r_state, w_next_state;
  logic [GW-1:0]   r_grant, r_last_grant, w_winner, w_idx;
  logic [CW-1:0]   r_count;
  logic            r_ilv_valid, r_busy, r_block_done;
  logic [BITS-1:0] r_ilv_data [V];
  logic            w_accept, w_last, w_found, w_any_req;
`ifdef INTERLEAVE_SCHED_PAD_TIMEOUT_EN
  logic [SW-1:0]   r_stall;
  logic            r_pad_active;
`endif

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    w_any_req    = |req_valid;
    w_winner     = r_last_grant;
    w_found      = 1'b0;
    w_idx        = '0;
    // Search starts one past the previous owner, wrapping modulo R.
    for (int k = 1; k <= R; k++) begin
      w_idx = GW'((int'(r_last_grant) + k) % R);
      if (!w_found && req_valid[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
    case (r_state)
      IDLE: if (w_any_req) w_next_state = PASS;
      PASS: begin
        w_accept = req_valid[r_grant];
        if (w_accept && r_count == CW'(L - 1)) begin
          w_last       = 1'b1;
          w_next_state = IDLE;
        end
`ifdef INTERLEAVE_SCHED_PAD_TIMEOUT_EN
        else if (!w_accept && r_stall == SW'(TIMEOUT - 1)) begin
          w_next_state = PAD;
        end
`endif
      end
`ifdef INTERLEAVE_SCHED_PAD_TIMEOUT_EN
      PAD: if (r_count == CW'(L - 1)) begin
        w_last       = 1'b1;
        w_next_state = IDLE;
      end
`endif
      default: w_next_state = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < R; gi++) begin : g_ready
      assign req_ready[gi] = (r_state == PASS) && (r_grant == GW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(R - 1);
      r_count      <= '0;
      r_ilv_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_block_done <= 1'b0;
      for (int v = 0; v < V; v++) r_ilv_data[v] <= '0;
    end else begin
      r_state      <= w_next_state;
      r_ilv_valid  <= 1'b0;
      r_block_done <= w_last;
      case (r_state)
        IDLE: begin
          r_busy <= w_any_req;
          if (w_any_req) begin
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
            r_count      <= '0;
          end
        end
        PASS: begin
          r_busy <= 1'b1;
          if (w_accept) begin
            r_ilv_valid <= 1'b1;
            for (int v = 0; v < V; v++) r_ilv_data[v] <= req_data[r_grant][v];
            r_count <= w_last ? '0 : r_count + CW'(1);
          end
        end
`ifdef INTERLEAVE_SCHED_PAD_TIMEOUT_EN
        PAD: begin
          r_busy      <= 1'b1;
          r_ilv_valid <= 1'b1;
          for (int v = 0; v < V; v++) r_ilv_data[v] <= '0;
          r_count <= w_last ? '0 : r_count + CW'(1);
        end
`endif
        default: r_busy <= 1'b0;
      endcase
    end
  end

`ifdef INTERLEAVE_SCHED_PAD_TIMEOUT_EN
  // Stall count only runs while the owner is idle in PASS; any acceptance clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall      <= '0;
      r_pad_active <= 1'b0;
    end else begin
      r_pad_active <= (r_state == PAD);
      if (r_state != PASS || w_accept) r_stall <= '0;
      else                             r_stall <= r_stall + SW'(1);
    end
  end
  assign pad_active = r_pad_active;
`else
  assign pad_active = 1'b0;
`endif

  assign ilv_in_valid = r_ilv_valid;
  assign ilv_data     = r_ilv_data;
  assign grant_id     = r_grant;
  assign busy         = r_busy;
  assign block_done   = r_block_done;
endmodule

// File: tb/tb_interleave_block_scheduler.sv
// Self-checking bench: per-cycle reference model, arbitration table, directed block
// scenarios (stall, mid-block reset, timeout) and randomized traffic.
module tb_interleave_block_scheduler;
  localparam int BITS = 8, IIR = 3, N = 10, V = 2, R = 4, TIMEOUT = 16;
  localparam int L = IIR * N, GW = $clog2(R);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [R-1:0]    req_valid = '0;
  logic [BITS-1:0] req_data [R][V];
  logic [R-1:0]    req_ready;
  logic            ilv_in_valid;
  logic [BITS-1:0] ilv_data [V];
  logic [GW-1:0]   grant_id;
  logic            busy, block_done, pad_active;

  interleave_block_scheduler #(.BITS(BITS), .IIR(IIR), .N(N), .V(V), .R(R), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .ilv_in_valid(ilv_in_valid), .ilv_data(ilv_data), .grant_id(grant_id), .busy(busy),
    .block_done(block_done), .pad_active(pad_active));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: owner is -1 when no block is open; cnt counts samples 1..L.
  int m_owner, m_cnt, m_last, m_stall, m_grant;
  bit m_pad, m_valid, m_done, m_busy, m_pad_o;
  logic [BITS-1:0] m_data [V];
  int sent [R];
  int n_out, n_done, n_pad, n_cyc;
  bit rand_data;

  typedef struct {
    logic [R-1:0] mask1;
    int           exp1;
    logic [R-1:0] mask2;
    int           exp2;
  } arb_vec_t;
  arb_vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_last = R - 1; m_stall = 0; m_grant = 0;
    m_pad = 0; m_valid = 0; m_done = 0; m_busy = 0; m_pad_o = 0;
    for (int v = 0; v < V; v++) m_data[v] = '0;
    for (int g = 0; g < R; g++) sent[g] = 0;
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    repeat (ncyc) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", ilv_in_valid, 0);
    chk("rst_data0", ilv_data[0], 0);
    chk("rst_data1", ilv_data[1], 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", block_done, 0);
    chk("rst_pad", pad_active, 0);
  endtask

  task automatic cycle();
    logic [R-1:0] exp_ready;
    bit found;
    if (!rand_data)
      for (int g = 0; g < R; g++)
        for (int v = 0; v < V; v++) req_data[g][v] = BITS'(sent[g] + 64 * v);
    m_valid = 0; m_done = 0; m_pad_o = 0;
    if (m_owner < 0) begin
      m_busy = (req_valid != 0);
      found = 0;
      for (int k = 1; k <= R; k++)
        if (!found && req_valid[(m_last + k) % R]) begin
          found = 1; m_owner = (m_last + k) % R;
        end
      if (found) begin
        m_last = m_owner; m_grant = m_owner; m_cnt = 0; m_stall = 0; m_pad = 0;
        for (int g = 0; g < R; g++) sent[g] = 0;
      end
    end else if (m_pad) begin
      m_busy = 1; m_valid = 1; m_pad_o = 1; m_cnt++;
      for (int v = 0; v < V; v++) m_data[v] = '0;
      if (m_cnt == L) begin m_done = 1; m_owner = -1; m_pad = 0; end
    end else if (req_valid[m_owner]) begin
      m_busy = 1; m_valid = 1; m_cnt++; m_stall = 0; sent[m_owner]++;
      for (int v = 0; v < V; v++) m_data[v] = req_data[m_owner][v];
      if (m_cnt == L) begin m_done = 1; m_owner = -1; end
    end else begin
      m_busy = 1;
`ifdef INTERLEAVE_SCHED_PAD_TIMEOUT_EN
      m_stall++;
      if (m_stall == TIMEOUT) m_pad = 1;
`endif
    end
    @(posedge clk);
    #1;
    n_cyc++;
    exp_ready = '0;
    if (m_owner >= 0 && !m_pad) exp_ready[m_owner] = 1'b1;
    chk("ready", req_ready, exp_ready);
    chk("ilv_valid", ilv_in_valid, m_valid);
    for (int v = 0; v < V; v++) chk("ilv_data", ilv_data[v], m_data[v]);
    chk("grant", grant_id, m_grant);
    chk("busy", busy, m_busy);
    chk("done", block_done, m_done);
    chk("pad", pad_active, m_pad_o);
    if (ilv_in_valid) n_out++;
    if (block_done)   n_done++;
    if (pad_active)   n_pad++;
  endtask

  task automatic run_block(output int outs, output int cyc);
    int o0 = n_out;
    int d0 = n_done;
    cyc = 0;
    while (n_done == d0 && cyc < 300) begin
      cycle();
      cyc++;
    end
    outs = n_out - o0;
    if (n_done == d0) begin
      checks++; errors++;
      $display("FAIL block_timeout: got no block_done after %0d cycles expected one", cyc);
    end
  endtask

  task automatic run_until_sent(input int g, input int k);
    int budget = 0;
    while (sent[g] < k && budget < 200) begin
      cycle();
      budget++;
    end
    if (sent[g] < k) begin
      checks++; errors++;
      $display("FAIL sent_timeout: got %0d samples from %0d expected %0d", sent[g], g, k);
    end
  endtask

  initial begin
    int outs, cyc, k, o0, d0, p0, c0;
    int order [5];
    vecs[0] = '{4'b0001, 0, 4'b0001, 0};
    vecs[1] = '{4'b1000, 3, 4'b1001, 0};
    vecs[2] = '{4'b0110, 1, 4'b0110, 2};
    vecs[3] = '{4'b1111, 0, 4'b1110, 1};
    vecs[4] = '{4'b0101, 0, 4'b0101, 2};
    vecs[5] = '{4'b1010, 1, 4'b0011, 0};
    order = '{0, 1, 2, 3, 0};
    n_out = 0; n_done = 0; n_pad = 0; n_cyc = 0; rand_data = 0;
    model_reset();
    for (int g = 0; g < R; g++)
      for (int v = 0; v < V; v++) req_data[g][v] = '0;

    // Single requester 2, data k on lane 0
    do_reset(2);
    req_valid = 4'b0100;
    k = 0; d0 = n_done;
    for (int c = 0; c < 40 && n_done == d0; c++) begin
      cycle();
      if (ilv_in_valid) begin
        chk("seq_data", ilv_data[0], k);
        chk("seq_grant", grant_id, 2);
        k++;
      end
    end
    chk("seq_count", k, L);
    chk("seq_done", n_done - d0, 1);
    req_valid = '0;
    cycle();

    // Arbitration table: two consecutive blocks per entry
    foreach (vecs[i]) begin
      do_reset(1);
      req_valid = vecs[i].mask1;
      run_block(outs, cyc);
      chk("tbl_grant1", grant_id, vecs[i].exp1);
      chk("tbl_outs1", outs, L);
      req_valid = vecs[i].mask2;
      run_block(outs, cyc);
      chk("tbl_grant2", grant_id, vecs[i].exp2);
      chk("tbl_outs2", outs, L);
    end

    // All requesting from reset: rotation with one arbitration cycle per block
    req_valid = 4'b1111;
    do_reset(2);
    for (int b = 0; b < 5; b++) begin
      run_block(outs, cyc);
      chk("rr_grant", grant_id, order[b]);
      chk("rr_outs", outs, L);
      chk("rr_period", cyc, L + 1);
    end

    // Requester 1 stalls 5 cycles after sample 12
    req_valid = '0;
    do_reset(1);
    o0 = n_out; c0 = n_cyc;
    req_valid = 4'b0010;
    run_until_sent(1, 13);
    req_valid = '0;
    repeat (5) cycle();
    chk("stall_busy", busy, 1);
    req_valid = 4'b0010;
    run_block(outs, cyc);
    chk("stall_outs", n_out - o0, L);
    chk("stall_cycles", n_cyc - c0, L + 1 + 5);
    chk("stall_grant", grant_id, 1);

    // Reset after sample 17 of requester 3 while everyone requests
    req_valid = 4'b1000;
    do_reset(1);
    run_until_sent(3, 18);
    req_valid = 4'b1111;
    d0 = n_done;
    do_reset(1);
    run_block(outs, cyc);
    chk("rst_mid_grant", grant_id, 0);
    chk("rst_mid_done", n_done - d0, 1);

    // Requester stops after sample 20
    req_valid = 4'b0001;
    do_reset(1);
    run_until_sent(0, 21);
    req_valid = '0;
    o0 = n_out; d0 = n_done; p0 = n_pad;
    repeat (40) cycle();
`ifdef INTERLEAVE_SCHED_PAD_TIMEOUT_EN
    chk("to_pad_samples", n_pad - p0, L - 21);
    chk("to_outs", n_out - o0, L - 21);
    chk("to_done", n_done - d0, 1);
    chk("to_busy", busy, 0);
`else
    chk("to_outs", n_out - o0, 0);
    chk("to_done", n_done - d0, 0);
    chk("to_busy", busy, 1);
    chk("to_pad", n_pad - p0, 0);
`endif

    // Randomized traffic with occasional resets
    rand_data = 1;
    do_reset(1);
    for (int c = 0; c < 1500; c++) begin
      for (int g = 0; g < R; g++) begin
        req_valid[g] = ($urandom_range(0, 99) < 70);
        for (int v = 0; v < V; v++) req_data[g][v] = BITS'($urandom);
      end
      if ($urandom_range(0, 299) == 0) do_reset(1);
      else cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
